dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Memory-side responder for the pipeline's MEM-stage data access (read/write enable, byte address, store data, func3). It accepts one request per handshake and sequences it against a word-organized, single-port synchronous SRAM that has no byte enables. It performs sub-word load extraction with sign/zero extension and sub-word stores via read-modify-write. A response pulse releases the MEM-stage stall.

Parameters:
DM_ADDRESS, 9, byte-address width; SRAM word address is DM_ADDRESS-2 bits.
DATA_W, 32, data width; fixed at 32.
SRAM_LAT, 1, cycles from an SRAM read-enable cycle to valid sram_rdata; legal range 1..4.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  DM_ADDRESS  byte address.
req_wdata  in  DATA_W  store data, right-aligned.
req_func3  in  3  RV32I width/sign code.
rsp_valid  out  1  single-cycle completion pulse.
rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
rsp_err  out  1  misaligned access or illegal func3; valid with rsp_valid.
sram_en  out  1  SRAM access this cycle.
sram_we  out  1  SRAM write this cycle.
sram_addr  out  DM_ADDRESS-2  word address.
sram_wdata  out  DATA_W  full write word.
sram_rdata  in  DATA_W  read word, SRAM_LAT cycles after a read-enable cycle.

Behaviour:
- Reset: reset low forces state IDLE immediately. Outputs while reset is low: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0. After release, req_ready=1.
- Reset asserted mid-operation: the request is abandoned, no response is issued, and no partial SRAM write occurs. sram_we is never asserted while reset is low.
- Handshake: req_ready=1 only in IDLE and not in a cycle where rsp_valid=1. Capture happens at cycle T when req_valid&req_ready. All req_* signals are registered at T and may change afterwards.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- Legality check (at capture):
  - Loads: func3 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU) are legal.
  - Stores: func3 0 (SB), 1 (SH), 2 (SW) are legal.
  - Halfword requires addr[0]=0. Word requires addr[1:0]=0.
  - Illegal request: IDLE -> RESP with no SRAM access. rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0.
- Load:
  - T+1 RD_ISSUE: sram_en=1, sram_we=0.
  - RD_WAIT counts SRAM_LAT-1 further cycles, then samples sram_rdata at T+1+SRAM_LAT.
  - RESP: rsp_valid at T+2+SRAM_LAT.
  - Result: byte selected by addr[1:0], halfword by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Word store: T+1 WR_ISSUE with sram_en=1, sram_we=1, sram_wdata=req_wdata. rsp_valid at T+2.
- Sub-word store (SB/SH):
  - Read the word as for a load.
  - Merge req_wdata[7:0] or [15:0] into the selected lane; other lanes are preserved.
  - WR_ISSUE at T+2+SRAM_LAT; rsp_valid at T+3+SRAM_LAT.
- RESP lasts exactly one cycle, then returns to IDLE. The next request is accepted no earlier than the cycle after rsp_valid. rsp_rdata/rsp_err hold their value until the next response.
- SRAM outputs are 0 whenever sram_en=0. Address wrap is not applicable: sram_addr = captured addr[DM_ADDRESS-1:2].
- Latency summary (SRAM_LAT=1): LW/LB 3, SW 2, SB/SH 4, error 1.

Decomposition:
- Shared package dmem_pkg:
  - func3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum dmem_state_t.
  - Captured-request struct (we, addr, wdata, func3).
- One natural sub-module, dmem_lane_align, combinational:
  - Load extract/extend.
  - Store merge.
  - Legality check.

Test Plan:
1. Initialize SW 0x8899AABB @0x010, then LW @0x010 -> rsp_valid at T+3, rdata 0x8899AABB, err 0. The SW responds at T+2.
2. LB @0x011 -> 0xFFFFFFAA. LBU @0x011 -> 0x000000AA. LH @0x012 -> 0xFFFF8899. LHU @0x012 -> 0x00008899.
3. SB 0x00000012 @0x013 -> SRAM read then write of 0x1299AABB, rsp at T+4. SH 0x0000CAFE @0x010 -> word becomes 0x1299CAFE.
4. LW @0x002, SH @0x011, and load func3=3 -> rsp_valid at T+1, err=1, rdata 0, sram_en never asserted.
5. Pull reset low during RD_WAIT of an SB @0x013 -> no sram_we and no rsp_valid. The word reads back unchanged; req_ready=1 one cycle after release.
6. req_valid held high with back-to-back LW/SW stream, then SRAM_LAT=3 -> one accept per response, no request lost or duplicated, load latency T+5.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: func3 codes, FSM state type and captured-request record for dmem_responder
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;
   typedef enum logic [2:0] {
      S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_RESP
   } dmem_state_t;
   // The word address lives in the top (its width follows DM_ADDRESS); only the byte lane is kept here.
   typedef struct packed {
      logic        we;
      logic [1:0]  lane;
      logic [31:0] wdata;
      logic [2:0]  func3;
   } dmem_req_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: legality check, load extract/extend and sub-word store merge
// Ports: we_i/func3_i/lane_i describe the access, wdata_i is the right-aligned store data,
//        rdata_i the SRAM word; legal_o, load_o (extended load value), merge_o (read-modify-write word).
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  func3_i,
   input  logic [1:0]  lane_i,
   input  logic [15:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic        legal_o,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);
   logic        is_b, is_h, is_w, sext;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [4:0]  sh;
   always_comb begin
      is_b    = func3_i == F3_B || (!we_i && func3_i == F3_BU);
      is_h    = func3_i == F3_H || (!we_i && func3_i == F3_HU);
      is_w    = func3_i == F3_W;
      legal_o = is_b || (is_h && !lane_i[0]) || (is_w && lane_i == 2'd0);
      sext    = !func3_i[2];
      byte_v  = lane_i == 2'd3 ? rdata_i[31:24] : lane_i == 2'd2 ? rdata_i[23:16] :
                lane_i[0] ? rdata_i[15:8] : rdata_i[7:0];
      half_v  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      load_o  = is_w ? rdata_i : is_h ? {{16{sext & half_v[15]}}, half_v} :
                {{24{sext & byte_v[7]}}, byte_v};
      sh      = {lane_i, 3'b000};
      merge_o = is_h ? (lane_i[1] ? {wdata_i, rdata_i[15:0]} : {rdata_i[31:16], wdata_i}) :
                (rdata_i & ~(32'hFF << sh)) | ({24'd0, wdata_i[7:0]} << sh);
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data access sequenced onto a word-wide single-port SRAM without byte enables
// Ports: req_* request handshake (byte address, right-aligned store data, func3), rsp_* one-cycle
//        completion with load data / error, sram_* word-addressed SRAM port with SRAM_LAT read latency.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int SRAM_LAT   = 1
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [DM_ADDRESS-1:0] req_addr_i,
   input  logic [DATA_W-1:0]     req_wdata_i,
   input  logic [2:0]            req_func3_i,
   output logic                  rsp_valid_o,
   output logic [DATA_W-1:0]     rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  sram_en_o,
   output logic                  sram_we_o,
   output logic [DM_ADDRESS-3:0] sram_addr_o,
   output logic [DATA_W-1:0]     sram_wdata_o,
   input  logic [DATA_W-1:0]     sram_rdata_i
);
   dmem_state_t           state_q, state_d;
   dmem_req_t             req_q, req_d, cur;
   logic [DM_ADDRESS-3:0] addr_q, addr_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  legal;
   logic [31:0]           load_w, merge_w;
   // One aligner serves both the capture-time legality check (live inputs) and the data path (captured request).
   assign cur = state_q == S_IDLE ?
                dmem_req_t'{we: req_we_i, lane: req_addr_i[1:0], wdata: req_wdata_i, func3: req_func3_i} : req_q;
   dmem_lane_align u_align (
      .we_i    (cur.we),
      .func3_i (cur.func3),
      .lane_i  (cur.lane),
      .wdata_i (cur.wdata[15:0]),
      .rdata_i (sram_rdata_i),
      .legal_o (legal),
      .load_o  (load_w),
      .merge_o (merge_w)
   );
   assign req_ready_o  = reset_ni && state_q == S_IDLE;
   assign rsp_valid_o  = state_q == S_RESP;
   assign rsp_rdata_o  = rdata_q;
   assign rsp_err_o    = err_q;
   assign sram_en_o    = state_q == S_RD_ISSUE || state_q == S_WR_ISSUE;
   assign sram_we_o    = state_q == S_WR_ISSUE;
   assign sram_addr_o  = sram_en_o ? addr_q : '0;
   assign sram_wdata_o = sram_we_o ? req_q.wdata : '0;
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (req_valid_i && req_ready_o) begin
            req_d   = cur;
            addr_d  = req_addr_i[DM_ADDRESS-1:2];
            state_d = !legal ? S_RESP : (req_we_i && req_func3_i == F3_W) ? S_WR_ISSUE : S_RD_ISSUE;
            if (!legal) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         S_RD_ISSUE: begin
            state_d = S_RD_WAIT;
            cnt_d   = '0;
         end
         S_RD_WAIT: if (cnt_q == 2'(SRAM_LAT - 1)) begin
            // Sub-word stores keep the merged word in the captured wdata so WR_ISSUE writes it unchanged.
            if (req_q.we) begin
               req_d.wdata = merge_w;
               state_d     = S_WR_ISSUE;
            end else begin
               rdata_d = load_w;
               err_d   = 1'b0;
               state_d = S_RESP;
            end
         end else cnt_d = cnt_q + 2'd1;
         S_WR_ISSUE: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
endmodule
